// File: rtl/axi_fifo_wdrain.sv
// Drains words from a synchronous FIFO read port onto an AXI4 write channel as INCR
// bursts at incrementing addresses, never crossing a 4kB boundary.
module axi_fifo_wdrain #(
  parameter int unsigned BW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned LGFLEN     = 4,
  parameter int unsigned LGMAXBURST = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [AW-1:0]     i_base_addr,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_err,
  input  logic [LGFLEN:0]   i_fifo_fill,
  input  logic              i_fifo_empty,
  input  logic [BW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [AW-1:0]     M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  output logic [BW-1:0]     M_AXI_WDATA,
  output logic [BW/8-1:0]   M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  input  logic [1:0]        M_AXI_BRESP
);

  localparam int unsigned SZ = $clog2(BW / 8);
  localparam int unsigned FW = LGFLEN + 1;
  localparam int unsigned CW = (FW > 13) ? FW : 13;
  localparam int unsigned LW = 9;
  localparam logic [CW-1:0] MAX_BEATS = CW'(1) << LGMAXBURST;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            wlast_q, wlast_d;
  logic            bready_q, bready_d;

  logic [CW-1:0]   room;
  logic [CW-1:0]   bound;
  logic [CW-1:0]   fill;
  logic [CW-1:0]   sel_len;
  logic            sel;
  logic            wr_hs;
  logic            unused_bresp0;

  assign unused_bresp0 = M_AXI_BRESP[0];

  // Beats left before the 4kB boundary, capped at the maximum burst length
  assign room  = (CW'(4096) - CW'(addr_q[11:0])) >> SZ;
  assign bound = (room < MAX_BEATS) ? room : MAX_BEATS;
  assign fill  = CW'(i_fifo_fill);
  assign wr_hs = wvalid_q && M_AXI_WREADY;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    busy_d    = busy_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    sel       = 1'b0;
    sel_len   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = i_base_addr;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Full bursts take priority; a flush only sends what is left
        if (fill >= bound) begin
          sel     = 1'b1;
          sel_len = bound;
        end else if (i_flush && (fill != '0)) begin
          sel     = 1'b1;
          sel_len = fill;
        end else if (i_flush && i_fifo_empty) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        if (sel) begin
          awaddr_d  = addr_q;
          awlen_d   = 8'(sel_len - CW'(1));
          len_d     = LW'(sel_len);
          awvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (len_q == LW'(1));
          beat_d    = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (wr_hs) begin
          beat_d = beat_q + LW'(1);
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            addr_d   = addr_q + (AW'(len_q) << SZ);
            state_d  = S_RESP;
          end else begin
            wlast_d = ((beat_q + LW'(2)) == len_q);
          end
        end
      end
      S_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP[1]) err_d = 1'b1;
          state_d  = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy        = busy_q;
  assign o_err         = err_q;
  assign o_fifo_rd     = wr_hs;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWSIZE  = 3'(SZ);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = i_fifo_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_axi_fifo_wdrain.sv
// Bench for axi_fifo_wdrain: queue-backed FIFO and AXI slave model, with a scoreboard
// of expected AW descriptors and write data compared as the DUT emits them.
module tb_axi_fifo_wdrain;

  localparam int unsigned BW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LGFLEN = 4;
  localparam int unsigned LGMAXBURST = 4;
  localparam int unsigned DEPTH = 1 << LGFLEN;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_start;
  logic [AW-1:0]   i_base_addr;
  logic            i_flush;
  logic            o_busy;
  logic            o_err;
  logic [LGFLEN:0] i_fifo_fill;
  logic            i_fifo_empty;
  logic [BW-1:0]   i_fifo_data;
  logic            o_fifo_rd;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [BW-1:0]   M_AXI_WDATA;
  logic [BW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [1:0]      M_AXI_BRESP;

  axi_fifo_wdrain #(
    .BW(BW), .AW(AW), .LGFLEN(LGFLEN), .LGMAXBURST(LGMAXBURST)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_flush(i_flush), .o_busy(o_busy), .o_err(o_err), .i_fifo_fill(i_fifo_fill),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_rd(o_fifo_rd),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;

  // Expected AW descriptors: written by the stimulus process, consumed by index in the model
  logic [AW-1:0] exp_aw_addr [0:63];
  int            exp_aw_len  [0:63];
  int            n_aw_exp;
  int            aw_idx = 0;

  logic [BW-1:0] fifo_q[$];
  logic [BW-1:0] exp_q[$];
  int push_req;
  int push_done = 0;
  int stall_en;
  int err_burst;
  int b_cnt = 0;
  int rd_cnt = 0;
  int awv_cycles = 0;
  int w_beat = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // FIFO + AXI slave model: observe at negedge, update after the following posedge
  initial begin : model
    int  cur_len;
    bit  f_rd, f_b, f_wlast;
    bit  p_awv, p_wv, p_wlast;
    logic [AW-1:0] p_awaddr;
    logic [7:0]    p_awlen;
    logic [BW-1:0] p_wdata, w;
    bit  b_pend;
    cur_len = 1; b_pend = 0;
    p_awv = 0; p_wv = 0; p_wlast = 0; p_awaddr = '0; p_awlen = '0; p_wdata = '0;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    i_fifo_fill = '0; i_fifo_empty = 1'b1; i_fifo_data = '0;
    forever begin
      @(negedge i_clk);
      f_rd = 0; f_b = 0; f_wlast = 0;
      if (!i_reset_n) begin
        w_beat = 0; p_awv = 0; p_wv = 0;
      end else begin
        if (M_AXI_AWVALID) awv_cycles++;
        if (p_awv) begin
          check_eq("aw_hold_valid", 64'(M_AXI_AWVALID), 64'd1);
          check_eq("aw_hold_addr", 64'(M_AXI_AWADDR), 64'(p_awaddr));
          check_eq("aw_hold_len", 64'(M_AXI_AWLEN), 64'(p_awlen));
        end
        if (p_wv) begin
          check_eq("w_hold_valid", 64'(M_AXI_WVALID), 64'd1);
          check_eq("w_hold_data", 64'(M_AXI_WDATA), 64'(p_wdata));
          check_eq("w_hold_last", 64'(M_AXI_WLAST), 64'(p_wlast));
        end
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          check_eq("aw_expected", 64'(aw_idx < n_aw_exp), 64'd1);
          if (aw_idx < n_aw_exp) begin
            check_eq("aw_addr", 64'(M_AXI_AWADDR), 64'(exp_aw_addr[aw_idx]));
            check_eq("aw_len", 64'(M_AXI_AWLEN), 64'(exp_aw_len[aw_idx]));
          end
          check_eq("aw_size_burst", 64'({M_AXI_AWSIZE, M_AXI_AWBURST}), 64'({3'd2, 2'b01}));
          cur_len = int'(M_AXI_AWLEN) + 1;
          aw_idx++;
          w_beat = 0;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          check_eq("fifo_rd", 64'(o_fifo_rd), 64'd1);
          check_eq("w_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check_eq("wdata", 64'(M_AXI_WDATA), 64'(exp_q.pop_front()));
          check_eq("wlast", 64'(M_AXI_WLAST), 64'(w_beat == cur_len - 1));
          check_eq("wstrb", 64'(M_AXI_WSTRB), 64'hF);
          f_rd = o_fifo_rd;
          w_beat++;
          if (M_AXI_WLAST) f_wlast = 1;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) f_b = 1;
        if (o_fifo_rd) rd_cnt++;
        p_awv = M_AXI_AWVALID && !M_AXI_AWREADY;
        p_awaddr = M_AXI_AWADDR; p_awlen = M_AXI_AWLEN;
        p_wv = M_AXI_WVALID && !M_AXI_WREADY;
        p_wdata = M_AXI_WDATA; p_wlast = M_AXI_WLAST;
      end
      @(posedge i_clk);
      #1;
      if (!i_reset_n) begin
        M_AXI_BVALID = 1'b0;
        b_pend = 0;
      end else begin
        if (f_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (f_b) M_AXI_BVALID = 1'b0;
        if (f_wlast) b_pend = 1;
        else if (b_pend && !M_AXI_BVALID) begin
          M_AXI_BVALID = 1'b1;
          M_AXI_BRESP = (b_cnt == err_burst) ? 2'b10 : 2'b00;
          b_cnt++;
          b_pend = 0;
        end
        if (push_done < push_req && fifo_q.size() < DEPTH) begin
          w = $urandom;
          fifo_q.push_back(w);
          exp_q.push_back(w);
          push_done++;
        end
        if (stall_en != 0) begin
          M_AXI_AWREADY = 1'($urandom_range(0, 1));
          M_AXI_WREADY = 1'($urandom_range(0, 1));
        end else begin
          M_AXI_AWREADY = 1'b1;
          M_AXI_WREADY = 1'b1;
        end
      end
      i_fifo_fill = (LGFLEN+1)'(fifo_q.size());
      i_fifo_empty = (fifo_q.size() == 0);
      i_fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic start(input logic [AW-1:0] a);
    i_base_addr = a;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic add_aw(input logic [AW-1:0] a, input int awlen);
    exp_aw_addr[n_aw_exp] = a;
    exp_aw_len[n_aw_exp] = awlen;
    n_aw_exp++;
  endtask

  task automatic finish_run(input string tag);
    int n;
    n = 0;
    while (push_done < push_req && n < 4000) begin tick(); n++; end
    check_eq({tag, "_pushed"}, 64'(push_done), 64'(push_req));
    i_flush = 1'b1;
    tick();
    n = 0;
    while (o_busy && n < 4000) begin tick(); n++; end
    i_flush = 1'b0;
    check_eq({tag, "_idle"}, 64'(o_busy), 64'd0);
    check_eq({tag, "_aw_count"}, 64'(aw_idx), 64'(n_aw_exp));
    check_eq({tag, "_data_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    int n, rd0, awv0;
    i_reset_n = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_base_addr = '0;
    stall_en = 0; push_req = 0; n_aw_exp = 0; err_burst = -1;
    #12;
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_err", 64'(o_err), 64'd0);
    check_eq("rst_fifo_rd", 64'(o_fifo_rd), 64'd0);
    check_eq("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    check_eq("rst_wvalid_wlast", 64'({M_AXI_WVALID, M_AXI_WLAST}), 64'd0);
    check_eq("rst_bready", 64'(M_AXI_BREADY), 64'd0);
    tick();
    i_reset_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 64'(o_busy), 64'd0);

    // Full 16-beat burst, ignored re-arm while busy, then a flushed 4-beat tail at 0x1040
    start(32'h0000_1000);
    check_eq("t1_busy", 64'(o_busy), 64'd1);
    start(32'hDEAD_0000);
    add_aw(32'h0000_1000, 15);
    add_aw(32'h0000_1040, 3);
    push_req += 20;
    finish_run("t1");

    // 4kB boundary split
    start(32'h0000_0FF8);
    add_aw(32'h0000_0FF8, 1);
    add_aw(32'h0000_1000, 13);
    push_req += 16;
    finish_run("t2");

    // Partial data never issues without flush
    start(32'h0000_3000);
    add_aw(32'h0000_3000, 4);
    awv0 = awv_cycles;
    push_req += 5;
    repeat (25) tick();
    check_eq("t3_no_early_aw", 64'(awv_cycles - awv0), 64'd0);
    finish_run("t3");
    check_eq("t3_fifo_empty", 64'(fifo_q.size()), 64'd0);

    // Random back-pressure on AW and W
    start(32'h0000_4000);
    stall_en = 1;
    rd0 = rd_cnt;
    for (int i = 0; i < 4; i++) add_aw(32'h0000_4000 + 32'(i * 64), 15);
    push_req += 64;
    finish_run("t4");
    check_eq("t4_rd_count", 64'(rd_cnt - rd0), 64'd64);
    stall_en = 0;

    // Error response on the second burst is sticky, cleared by re-arm
    start(32'h0000_5000);
    err_burst = b_cnt + 1;
    for (int i = 0; i < 3; i++) add_aw(32'h0000_5000 + 32'(i * 64), 15);
    push_req += 48;
    finish_run("t5");
    check_eq("t5_err_sticky", 64'(o_err), 64'd1);
    err_burst = -1;
    start(32'h0000_6000);
    check_eq("t5_err_cleared", 64'(o_err), 64'd0);
    finish_run("t5b");

    // Async reset during the third beat, then restart draining the leftover words
    start(32'h0000_7000);
    add_aw(32'h0000_7000, 15);
    push_req += 16;
    n = 0;
    while (!(w_beat == 2 && M_AXI_WVALID) && n < 500) begin tick(); n++; end
    check_eq("t6_reach_beat3", 64'(n < 500), 64'd1);
    i_reset_n = 1'b0;
    #1;
    check_eq("t6_rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    check_eq("t6_rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    check_eq("t6_rst_bready", 64'(M_AXI_BREADY), 64'd0);
    check_eq("t6_rst_busy", 64'(o_busy), 64'd0);
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
    check_eq("t6_fifo_left", 64'(fifo_q.size()), 64'd14);
    start(32'h0000_8000);
    add_aw(32'h0000_8000, 13);
    finish_run("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
